if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 Parameter BUF_DEPTH, default 2, fetch-buffer entries; only value 2 is required to be supported.
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 STALL  input  1  decode hazard hold; output register keeps its value.
REQ-006 BR_TAKEN  input  1  redirect request from a later stage.
REQ-007 BR_TARGET  input  32  redirect byte address.
REQ-008 IMEM_REQ  output  1  instruction-memory request valid.
REQ-009 IMEM_ADDR  output  32  request byte address, word aligned.
REQ-010 IMEM_GNT  input  1  request accepted this cycle.
REQ-011 IMEM_RVALID  input  1  read data valid.
REQ-012 IMEM_RDATA  input  32  instruction word.
REQ-013 INSTR  output  32  instruction to decode.
REQ-014 PC_OUT  output  32  byte address of INSTR.
REQ-015 VALID_OUT  output  1  INSTR/PC_OUT hold a real instruction.

Function
REQ-016 A fetch PC register SHALL hold the next address to request; IMEM_ADDR SHALL equal it.
REQ-017 At most one memory request SHALL be outstanding (granted, RVALID not yet received).
REQ-018 FSM states SHALL be FETCH (IMEM_REQ=1 when credit allows), WAIT (outstanding, keep), DROP (outstanding, discard).
REQ-019 FETCH->WAIT on IMEM_GNT with no BR_TAKEN; fetch PC += 4 on that edge; 32-bit wrap from FFFF_FFFC to 0000_0000.
REQ-020 WAIT->FETCH on IMEM_RVALID; {PC, IMEM_RDATA} SHALL be pushed into the fetch buffer that edge.
REQ-021 Credit rule: IMEM_REQ SHALL be 1 in FETCH only if buffer occupancy + outstanding < BUF_DEPTH.
REQ-022 Buffer SHALL be a FIFO of {pc, instr}; never overflow, never read empty.
REQ-023 When STALL=0: if buffer non-empty, output register SHALL load the head and set VALID_OUT=1; else INSTR=0, PC_OUT=0, VALID_OUT=0.
REQ-024 When STALL=1 and BR_TAKEN=0: output register and buffer head SHALL be unchanged; fetching continues within credit.
REQ-025 Latency: RVALID at edge n with empty buffer, STALL=0 SHALL give VALID_OUT=1 after edge n+1.
REQ-026 BR_TAKEN SHALL take priority over STALL: on that edge, buffer cleared, output register cleared (VALID_OUT=0, INSTR=0), fetch PC := BR_TARGET.
REQ-027 BR_TAKEN in WAIT, or in FETCH together with IMEM_GNT, SHALL move FSM to DROP; the returning RVALID SHALL be discarded, then DROP->FETCH.
REQ-028 BR_TAKEN in DROP SHALL update fetch PC only and remain in DROP.
REQ-029 BR_TARGET low two bits SHALL be forced to 0.
REQ-030 IMEM_RVALID outside WAIT/DROP SHALL be ignored.

Reset
REQ-031 RST_N=0 SHALL immediately set fetch PC=RESET_PC, FSM=FETCH, buffer empty, outstanding=0, INSTR=0, PC_OUT=0, VALID_OUT=0, IMEM_REQ=0 during reset.
REQ-032 A response arriving after reset release for a request issued before reset SHALL NOT be accepted by a compliant memory; the stage SHALL ignore RVALID while not in WAIT/DROP.

Structure
REQ-033 FSM state encoding, NOP word 32'h0 and instruction-word width SHALL live in the shared pipeline package with the opcode/category constants.
REQ-034 The fetch buffer SHALL be one sub-module, fetch_fifo (parameterised depth, {pc,instr} payload, push/pop/flush, count).

Verification
REQ-035 Reset release, GNT always 1, RVALID one cycle after GNT, words A0..A3 -> VALID_OUT=1 with PC_OUT 0,4,8,C in order, no gaps after fill.
REQ-036 STALL=1 for 5 cycles after first valid -> INSTR/PC_OUT frozen, IMEM_REQ drops once buffer holds 2 entries, no lost/duplicated PC on release.
REQ-037 BR_TAKEN=1, BR_TARGET=0x100 while WAIT for PC 0x8 -> response for 0x8 discarded, next VALID_OUT shows PC_OUT=0x100.
REQ-038 BR_TAKEN and STALL both 1 -> VALID_OUT=0 next cycle, buffer empty, fetch restarts at target.
REQ-039 RESET_PC=32'hFFFF_FFFC -> second request IMEM_ADDR=0x0000_0000.
REQ-040 RST_N asserted mid-WAIT with STALL=1 -> all outputs 0 immediately, first post-reset request at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: word widths, NOP, fetch FSM encoding,
// fetch-buffer payload and the opcode/category constants used by decode.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  typedef enum logic [2:0] {
    CAT_ALU    = 3'd0,
    CAT_LOAD   = 3'd1,
    CAT_STORE  = 3'd2,
    CAT_BRANCH = 3'd3,
    CAT_JUMP   = 3'd4,
    CAT_SYSTEM = 3'd5,
    CAT_ILLEGAL = 3'd7
  } instr_cat_e;

  // Clear the two byte-offset bits so an address is word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: small FIFO of fetched {pc, instr} entries with flush.
// Push when full and pop when empty are ignored; the fetch stage's credit
// scheme keeps both from happening.
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && (cnt_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Pointer and occupancy next state; flush empties the buffer outright.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = inc_ptr(wr_q);
      if (do_pop)  rd_d = inc_ptr(rd_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, a small fetch
// buffer with credit-based request throttling, and a decode-facing output
// register that honours stall and branch redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            STALL,
  input  logic            BR_TAKEN,
  input  logic [XLEN-1:0] BR_TARGET,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [ILEN-1:0] IMEM_RDATA,
  output logic [ILEN-1:0] INSTR,
  output logic [XLEN-1:0] PC_OUT,
  output logic            VALID_OUT
);

  localparam int unsigned      CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CNT_W-1:0] fifo_count, count_d;
  fetch_entry_t     push_entry, head_entry;
  logic             gnt_ok;
  logic [XLEN-1:0]  br_pc;

  assign gnt_ok = req_q & IMEM_GNT;
  assign br_pc  = align_word(BR_TARGET);

  // In WAIT the fetch PC has already advanced past the granted address and
  // any redirect leaves WAIT for DROP, so the returning word belongs to pc-4.
  assign push_entry = '{pc: pc_q - XLEN'(4), instr: IMEM_RDATA};

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .head_o  (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Fetch FSM next state and fetch PC.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fifo_push = 1'b0;
    case (state_q)
      FS_FETCH: begin
        if (gnt_ok) state_d = BR_TAKEN ? FS_DROP : FS_WAIT;
        if (BR_TAKEN)    pc_d = br_pc;
        else if (gnt_ok) pc_d = pc_q + XLEN'(4);
      end
      FS_WAIT: begin
        // A redirect on the response edge discards the word in place; the
        // request is already closed, so fetching restarts immediately.
        if (BR_TAKEN) begin
          pc_d    = br_pc;
          state_d = IMEM_RVALID ? FS_FETCH : FS_DROP;
        end else if (IMEM_RVALID) begin
          fifo_push = 1'b1;
          state_d   = FS_FETCH;
        end
      end
      FS_DROP: begin
        if (BR_TAKEN)    pc_d    = br_pc;
        if (IMEM_RVALID) state_d = FS_FETCH;
      end
      default: state_d = FS_FETCH;
    endcase
  end

  // Output register and buffer pop; redirect outranks stall.
  always_comb begin
    fifo_flush = BR_TAKEN;
    fifo_pop   = 1'b0;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    if (BR_TAKEN) begin
      instr_d  = NOP_WORD;
      pc_out_d = '0;
      valid_d  = 1'b0;
    end else if (!STALL) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        instr_d  = head_entry.instr;
        pc_out_d = head_entry.pc;
        valid_d  = 1'b1;
      end else begin
        instr_d  = NOP_WORD;
        pc_out_d = '0;
        valid_d  = 1'b0;
      end
    end
  end

  // Request is registered, so credit is judged on next-cycle occupancy.
  always_comb begin
    if (fifo_flush) count_d = '0;
    else            count_d = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    req_d = (state_d == FS_FETCH) && (count_d < DEPTH_C);
  end

  // Fetch FSM, fetch PC and request registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FS_FETCH;
      pc_q    <= align_word(RESET_PC);
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
    end
  end

  // Decode-facing output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr_q  <= NOP_WORD;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign INSTR     = instr_q;
  assign PC_OUT    = pc_out_q;
  assign VALID_OUT = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a randomized memory responder plus a
// queue-based reference of the fetch stream, with directed scenarios for
// fill order, stall back-pressure, redirects, PC wrap and reset.
module tb_if_stage;

  localparam logic [31:0] PC0   = 32'h0000_0000;
  localparam logic [31:0] PC1   = 32'hFFFF_FFFC;
  localparam int unsigned DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        STALL, BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT, IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTR, PC_OUT;
  logic        VALID_OUT;

  logic        stall1, br1, req1, gnt1, rvalid1, valid1;
  logic [31:0] tgt1, addr1, rdata1, instr1, pcout1;

  always #5 CLK = ~CLK;

  if_stage #(.RESET_PC(PC0), .BUF_DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .INSTR(INSTR), .PC_OUT(PC_OUT), .VALID_OUT(VALID_OUT)
  );

  if_stage #(.RESET_PC(PC1), .BUF_DEPTH(DEPTH)) u_dut_wrap (
    .CLK(CLK), .RST_N(RST_N), .STALL(stall1), .BR_TAKEN(br1),
    .BR_TARGET(tgt1), .IMEM_REQ(req1), .IMEM_ADDR(addr1),
    .IMEM_GNT(gnt1), .IMEM_RVALID(rvalid1), .IMEM_RDATA(rdata1),
    .INSTR(instr1), .PC_OUT(pcout1), .VALID_OUT(valid1)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference state: buffered entries, fetch PC, redirect epoch, output regs
  ent_t        fq[$];
  logic [31:0] m_pc;
  int unsigned epoch = 0;
  logic        exp_valid;
  logic [31:0] exp_instr, exp_pc;
  // Memory responder state
  bit          mem_busy;
  logic [31:0] mem_pc;
  int unsigned mem_epoch, mem_delay;
  int unsigned gnt_pct, max_delay;
  bit          busy1;
  // PCs seen on the DUT output each time the reference consumed an entry
  logic [31:0] dlog[$];
  logic [31:0] addr1_log[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA000_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
    gnt1 = 1'b0; rvalid1 = 1'b0;
    #1;
    check_eq("rst_valid", 32'(VALID_OUT), 32'd0);
    check_eq("rst_instr", INSTR, 32'd0);
    check_eq("rst_pc_out", PC_OUT, 32'd0);
    check_eq("rst_req", 32'(IMEM_REQ), 32'd0);
    check_eq("rst_addr", IMEM_ADDR, PC0);
    check_eq("rst_req_wrap", 32'(req1), 32'd0);
    check_eq("rst_addr_wrap", addr1, PC1);
    fq.delete();
    m_pc = PC0; epoch++;
    exp_valid = 1'b0; exp_instr = '0; exp_pc = '0;
    mem_busy = 1'b0; mem_delay = 0; busy1 = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // One clock: drive inputs, advance the reference on the edge, then check.
  task automatic step(input logic stall, input logic br, input logic [31:0] tgt);
    logic        req, grant, resp, grant1, popped;
    logic [31:0] addr, a1;
    ent_t        e;
    STALL = stall; BR_TAKEN = br; BR_TARGET = tgt;
    resp = mem_busy && (mem_delay == 0);
    IMEM_RVALID = resp;
    IMEM_RDATA  = resp ? word_of(mem_pc) : $urandom();
    req  = IMEM_REQ;
    addr = IMEM_ADDR;
    IMEM_GNT = req && ($urandom_range(99) < gnt_pct);
    grant = IMEM_GNT;
    rvalid1 = busy1; rdata1 = $urandom();
    gnt1 = req1; grant1 = req1; a1 = addr1;
    popped = 1'b0;
    @(posedge CLK);
    if (br) begin
      fq.delete();
      exp_valid = 1'b0; exp_instr = '0; exp_pc = '0;
    end else if (!stall) begin
      if (fq.size() != 0) begin
        e = fq.pop_front();
        exp_valid = 1'b1; exp_instr = e.instr; exp_pc = e.pc;
        popped = 1'b1;
      end else begin
        exp_valid = 1'b0; exp_instr = '0; exp_pc = '0;
      end
    end
    if (resp) begin
      mem_busy = 1'b0;
      if (!br && mem_epoch == epoch) fq.push_back('{pc: mem_pc, instr: word_of(mem_pc)});
    end else if (mem_busy && mem_delay > 0) begin
      mem_delay--;
    end
    if (grant) begin
      mem_busy = 1'b1; mem_pc = addr; mem_epoch = epoch;
      mem_delay = $urandom_range(max_delay);
    end
    if (br) begin
      m_pc = tgt & ~32'h3;
      epoch++;
    end else if (grant) begin
      m_pc = m_pc + 32'd4;
    end
    busy1 = grant1;
    if (grant1 && addr1_log.size() < 4) addr1_log.push_back(a1);
    @(negedge CLK);
    check_eq("valid_out", 32'(VALID_OUT), 32'(exp_valid));
    check_eq("instr", INSTR, exp_instr);
    check_eq("pc_out", PC_OUT, exp_pc);
    check_eq("imem_req", 32'(IMEM_REQ), 32'(!mem_busy && fq.size() < DEPTH));
    if (IMEM_REQ) check_eq("imem_addr", IMEM_ADDR, m_pc);
    if (popped) dlog.push_back(PC_OUT);
  endtask

  initial begin
    bit found;
    RST_N = 1'b1;
    STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
    stall1 = 1'b0; br1 = 1'b0; tgt1 = '0; gnt1 = 1'b0; rvalid1 = 1'b0; rdata1 = '0;
    gnt_pct = 100; max_delay = 0;
    #2;
    do_reset();

    // In-order fill with an always-granting, next-cycle memory
    repeat (14) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("fill_pc%0d", i), (i < dlog.size()) ? dlog[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // Stall back-pressure, then release: the stream must stay contiguous
    repeat (5) step(1'b1, 1'b0, '0);
    check_eq("stall_req_drop", 32'(IMEM_REQ), 32'd0);
    repeat (12) step(1'b0, 1'b0, '0);
    check_eq("stream_len", 32'(dlog.size() > 6), 32'd1);
    for (int i = 0; i < dlog.size(); i++)
      check_eq($sformatf("stream_pc%0d", i), dlog[i], 32'(4 * i));

    // Redirect while waiting on the response for 0x8
    do_reset();
    max_delay = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_busy && mem_pc == 32'h8) found = 1'b1;
      else step(1'b0, 1'b0, '0);
    end
    check_eq("wait_pc8_seen", 32'(found), 32'd1);
    step(1'b0, 1'b1, 32'h100);
    dlog.delete();
    for (int i = 0; i < 40 && dlog.size() == 0; i++) step(1'b0, 1'b0, '0);
    check_eq("br_first_pc", (dlog.size() != 0) ? dlog[0] : 32'hDEAD_BEEF, 32'h100);

    // Redirect together with stall, unaligned target
    repeat (6) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h203);
    check_eq("br_stall_valid", 32'(VALID_OUT), 32'd0);
    dlog.delete();
    for (int i = 0; i < 40 && dlog.size() == 0; i++) step(1'b0, 1'b0, '0);
    check_eq("br_stall_first_pc", (dlog.size() != 0) ? dlog[0] : 32'hDEAD_BEEF, 32'h200);

    // Randomized traffic: grants, latencies, stalls and redirects
    gnt_pct = 70; max_delay = 3;
    for (int i = 0; i < 3000; i++) begin
      logic        s, b;
      logic [31:0] t;
      s = ($urandom_range(99) < 30);
      b = ($urandom_range(99) < 5);
      t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                   : ($urandom() & 32'h0000_FFFF);
      step(s, b, t);
    end

    // Reset asserted mid-WAIT while stalled
    gnt_pct = 100; max_delay = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_busy) found = 1'b1;
      else step(1'b1, 1'b0, '0);
    end
    check_eq("mid_wait_seen", 32'(found), 32'd1);
    STALL = 1'b1;
    do_reset();
    step(1'b0, 1'b0, '0);
    check_eq("post_rst_req", 32'(IMEM_REQ), 32'd1);
    check_eq("post_rst_addr", IMEM_ADDR, PC0);
    repeat (10) step(1'b0, 1'b0, '0);

    // Wrap instance: first two requests
    check_eq("wrap_req0", (addr1_log.size() > 0) ? addr1_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check_eq("wrap_req1", (addr1_log.size() > 1) ? addr1_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
